// File: rtl/hs_chan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hs_chan_arbiter
// Description : Round-robin arbiter that shares one four-phase bundled-data
//               channel (ch_req/ch_ack/ch_data) among N synchronous
//               requesters. Each transfer runs a full return-to-zero
//               handshake with the self-timed pipeline. The winner then gets
//               a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N           number of requesters (2..16)
//   W           data width per requester
//   SYNC_STAGES flops in the ch_ack synchroniser (>=2)
// Ports
//   clk      in   1    clock; all state updates on the rising edge
//   rst      in   1    asynchronous active-low reset, released synchronously
//   req      in   N    level request per requester; hold it with data until done
//   data_in  in   N*W  requester i data at [i*W +: W]
//   lock     in   N    (HS_ARB_LOCK_EN only) keep the grant for another transfer
//   gnt      out  N    one-hot grant, registered
//   done     out  N    one-cycle completion pulse, one-hot
//   ch_req   out  1    four-phase request to the async pipeline, registered
//   ch_data  out  W    bundled data, registered, stable for the whole handshake
//   ch_ack   in   1    four-phase acknowledge from the async pipeline
// Configuration
//   HS_ARB_LOCK_EN : when defined, adds the lock input. A locked winner that
//                    still requests keeps the channel without rearbitration.
// ============================================================================
module hs_chan_arbiter #(
    parameter int N           = 4,
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   data_in,
`ifdef HS_ARB_LOCK_EN
    input  logic [N-1:0]     lock,
`endif
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     done,
    output logic             ch_req,
    output logic [W-1:0]     ch_data,
    input  logic             ch_ack
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_REQ_HI = 3'd2,
        ST_REQ_LO = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                 r_state;
    logic [PW-1:0]          r_ptr;
    logic [N-1:0]           r_gnt;
    logic [N-1:0]           r_done;
    logic                   r_ch_req;
    logic [W-1:0]           r_ch_data;
    logic [SYNC_STAGES-1:0] r_sync;

    logic                   w_ack_s;
    logic                   w_found;
    logic [PW-1:0]          w_win;
    logic [PW-1:0]          w_cand;

    // ch_ack comes from the self-timed domain, so it is only used after
    // passing through the synchroniser chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ch_ack};
        end
    end

    assign w_ack_s = r_sync[SYNC_STAGES-1];

    // Round-robin search. Start at the requester after the last winner so
    // that the last winner ends up with the lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = PW'((int'(r_ptr) + k) % N);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Main sequencer. ch_req is driven straight from a flop so the async
    // pipeline never sees a glitch. The SETUP cycle gives ch_data a full
    // clock of settling time before ch_req rises (bundling margin).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= PW'(N - 1);
            r_gnt     <= '0;
            r_done    <= '0;
            r_ch_req  <= 1'b0;
            r_ch_data <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt     <= {{(N-1){1'b0}}, 1'b1} << w_win;
                        r_ch_data <= data_in[int'(w_win)*W +: W];
                        r_ptr     <= w_win;
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_ch_req <= 1'b1;
                    r_state  <= ST_REQ_HI;
                end
                ST_REQ_HI: begin
                    if (w_ack_s) begin
                        r_ch_req <= 1'b0;
                        r_state  <= ST_REQ_LO;
                    end
                end
                ST_REQ_LO: begin
                    // The return-to-zero phase is complete only when ack is
                    // seen low again.
                    if (!w_ack_s) begin
                        r_done  <= r_gnt;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
`ifdef HS_ARB_LOCK_EN
                    // A locked winner keeps its grant and pointer. Reload its
                    // data and start the next handshake directly.
                    if (lock[r_ptr] && req[r_ptr]) begin
                        r_ch_data <= data_in[int'(r_ptr)*W +: W];
                        r_state   <= ST_SETUP;
                    end else begin
                        r_gnt   <= '0;
                        r_state <= ST_IDLE;
                    end
`else
                    r_gnt   <= '0;
                    r_state <= ST_IDLE;
`endif
                end
                default: begin
                    r_gnt    <= '0;
                    r_ch_req <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign ch_req  = r_ch_req;
    assign ch_data = r_ch_data;

endmodule
`default_nettype wire

// File: tb/tb_hs_chan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hs_chan_arbiter
// Description : Self-checking bench for hs_chan_arbiter (N=4, W=8, 2-stage
//               synchroniser). It models the async pipeline as an ack
//               responder with a programmable delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_chan_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] data_in = '0;
`ifdef HS_ARB_LOCK_EN
    logic [N-1:0]   lock = '0;
`endif
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           ch_req;
    logic [W-1:0]   ch_data;
    logic           ch_ack;

    int total = 0;
    int bad   = 0;
    int ack_dly = 1;
    int ack_cnt;

    hs_chan_arbiter #(.N(N), .W(W), .SYNC_STAGES(S)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data_in (data_in),
`ifdef HS_ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .done    (done),
        .ch_req  (ch_req),
        .ch_data (ch_data),
        .ch_ack  (ch_ack)
    );

    always #5 clk = ~clk;

    // Async pipeline model: ack follows ch_req after ack_dly clocks. It is
    // reset by the same rst as the arbiter.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_ack  <= 1'b0;
            ack_cnt <= 0;
        end else if (ch_req != ch_ack) begin
            if (ack_cnt >= ack_dly - 1) begin
                ch_ack  <= ch_req;
                ack_cnt <= 0;
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end else begin
            ack_cnt <= 0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(output logic [N-1:0] d);
        int n = 0;
        while (done == '0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        d = done;
        if (done == '0) check("done_timeout", 32'(done), 32'hFFFF_FFFF);
    endtask

    typedef struct packed {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_gnt;
        logic [7:0]  exp_data;
        logic [7:0]  dly;
    } vec_t;

    // One complete transfer. req is dropped and data_in is scrambled right
    // after the grant; neither change may affect the transfer in flight.
    task automatic run_vec(input vec_t v);
        int n;
        int hi;
        int lo;
        logic stable;
        ack_dly = int'(v.dly);
        req     = v.req;
        data_in = v.data;
        n = 0;
        while (gnt == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("vec_gnt", 32'(gnt), 32'(v.exp_gnt));
        req     = '0;
        data_in = ~v.data;
        n = 0;
        while (!ch_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("vec_data_before_req", 32'(ch_data), 32'(v.exp_data));
        stable = 1'b1;
        hi = 0;
        while (ch_req && hi < 500) begin
            stable &= (gnt == v.exp_gnt) && (ch_data == v.exp_data) && (done == '0);
            hi++;
            @(negedge clk);
        end
        check("vec_req_hi_cycles", 32'(hi), 32'(int'(v.dly) + S + 1));
        lo = 0;
        while (done == '0 && lo < 500) begin
            stable &= !ch_req && (gnt == v.exp_gnt) && (ch_data == v.exp_data);
            lo++;
            @(negedge clk);
        end
        check("vec_req_lo_cycles", 32'(lo), 32'(int'(v.dly) + S + 1));
        check("vec_done", 32'(done), 32'(v.exp_gnt));
        check("vec_stable", 32'(stable), 32'd1);
        @(negedge clk);
        check("vec_done_cleared", 32'(done), 32'd0);
        check("vec_gnt_cleared", 32'(gnt), 32'd0);
    endtask

    vec_t vecs [9];

    initial begin
        logic [N-1:0] d;
        logic [N-1:0] exp_seq [5];
        int n;

        // Expected values are hand-computed from the round-robin pointer.
        // The pointer is 3 when the table starts.
        vecs[0] = '{req: 4'b0100, data: 32'h00A5_0000, exp_gnt: 4'b0100, exp_data: 8'hA5, dly: 8'd1};
        vecs[1] = '{req: 4'b1001, data: 32'h3C00_00C3, exp_gnt: 4'b1000, exp_data: 8'h3C, dly: 8'd1};
        vecs[2] = '{req: 4'b1001, data: 32'h3C00_00C3, exp_gnt: 4'b0001, exp_data: 8'hC3, dly: 8'd1};
        vecs[3] = '{req: 4'b0110, data: 32'h005A_6900, exp_gnt: 4'b0010, exp_data: 8'h69, dly: 8'd1};
        vecs[4] = '{req: 4'b0110, data: 32'h005A_6900, exp_gnt: 4'b0100, exp_data: 8'h5A, dly: 8'd1};
        vecs[5] = '{req: 4'b0011, data: 32'h0000_FF01, exp_gnt: 4'b0001, exp_data: 8'h01, dly: 8'd1};
        vecs[6] = '{req: 4'b1000, data: 32'h8000_0000, exp_gnt: 4'b1000, exp_data: 8'h80, dly: 8'd1};
        vecs[7] = '{req: 4'b1000, data: 32'hFF00_0000, exp_gnt: 4'b1000, exp_data: 8'hFF, dly: 8'd1};
        vecs[8] = '{req: 4'b0010, data: 32'h0000_7700, exp_gnt: 4'b0010, exp_data: 8'h77, dly: 8'd20};

        // Reset with every requester active.
        rst     = 1'b0;
        req     = 4'hF;
        data_in = {8'h13, 8'h12, 8'h11, 8'h10};
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ch_req", 32'(ch_req), 32'd0);
        check("rst_ch_data", 32'(ch_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("first_gnt", 32'(gnt), 32'b0001);

        // Round robin with all requests held for 8 transfers.
        for (int t = 0; t < 8; t++) begin
            wait_done(d);
            check("rr_done", 32'(d), 32'(4'b0001 << (t % 4)));
            check("rr_data", 32'(ch_data), 32'(8'h10 + (t % 4)));
            if (t == 7) req = '0;
            @(negedge clk);
            check("rr_idle_gnt", 32'(gnt), 32'd0);
        end
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset in REQ_HI. ch_req must drop before the next clock edge.
        ack_dly = 20;
        data_in = 32'h0000_0042;
        req     = 4'b0001;
        n = 0;
        while (!ch_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midrst_req_seen", 32'(ch_req), 32'd1);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_ch_req_async", 32'(ch_req), 32'd0);
        check("midrst_gnt_async", 32'(gnt), 32'd0);
        req = '0;
        @(negedge clk);
        check("midrst_ch_data", 32'(ch_data), 32'd0);
        ack_dly = 1;
        data_in = {8'h00, 8'h00, 8'hB1, 8'hB0};
        req     = 4'b0011;
        rst     = 1'b1;

        // Lock sequence. The first winner being 0 also shows that the pointer
        // was reset to N-1 (the pointer had been 0 before the reset).
`ifdef HS_ARB_LOCK_EN
        lock = 4'b0010;
        exp_seq = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
`else
        exp_seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif
        for (int t = 0; t < 5; t++) begin
            wait_done(d);
            check("seq_done", 32'(d), 32'(exp_seq[t]));
            check("seq_data", 32'(ch_data), (exp_seq[t] == 4'b0001) ? 32'hB0 : 32'hB1);
`ifdef HS_ARB_LOCK_EN
            if (t == 3) lock = '0;
`endif
            if (t == 4) req = '0;
            if (t == 1) begin
                @(negedge clk);
`ifdef HS_ARB_LOCK_EN
                check("seq_gnt_after_done", 32'(gnt), 32'b0010);
`else
                check("seq_gnt_after_done", 32'(gnt), 32'd0);
`endif
            end else begin
                @(negedge clk);
            end
        end
        repeat (3) @(negedge clk);
        check("final_idle_gnt", 32'(gnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
